inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
Encode-side counterpart of the instruction decoder: packs an operation class, ALU control code and register/immediate fields into a 32-bit MIPS-style instruction word.
- R-type: funct is the inverse of the ALU control mapping.
- Encoded words are buffered in a small FIFO and presented to the consumer (instruction memory loader or decoder test driver) with valid/ready handshakes on both sides.
- Unsupported R-type ALU codes are rejected and counted.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 16, width of issued-instruction counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries a fields bundle
in_ready  output  1  encoder can accept this cycle
in_kind  input  2  00 R-type, 01 lw, 10 sw, 11 beq
in_alu_ctr  input  4  ALU control code (R-type only)
in_rs  input  5  source register
in_rt  input  5  target register
in_rd  input  5  destination register (R-type only)
in_shamt  input  5  shift amount (R-type only)
in_imm  input  16  immediate/offset (I-type only)
out_valid  output  1  out_inst holds a valid word
out_ready  input  1  consumer takes word this cycle
out_inst  output  32  encoded instruction (FIFO head)
err  output  1  one-cycle pulse: R-type input rejected
err_cnt  output  8  rejected-input count, saturates at 255
issued_cnt  output  CNT_W  words delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst_n=0) clears:
  - FIFO pointers, count and contents to 0
  - out_valid=0, out_inst=0, err=0, err_cnt=0, issued_cnt=0
  - in_ready=1 on the first cycle after release
- Reset mid-operation discards all buffered words; no partial state survives.
- Accept: in_valid & in_ready. in_ready = (count != DEPTH).
  - Full FIFO blocks the push even if a pop occurs in the same cycle (no push-through).
- Encoding (combinational from inputs, written into the FIFO on accept):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}
    - alu_ctr 0010 -> funct 100000 (add)
    - 0110 -> 100010 (sub)
    - 0000 -> 100100 (and)
    - 0001 -> 100101 (or)
    - Any other alu_ctr -> reject.
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - I-type ignores alu_ctr, rd and shamt.
- Reject:
  - Input is still accepted (in_ready semantics unchanged) but nothing is written to the FIFO.
  - err=1 in the following cycle only; err_cnt increments, holding at 255.
- Output:
  - out_valid = (count != 0); out_inst = mem[rd_ptr], registered.
  - Latency: push in cycle N -> out_valid=1 in cycle N+1 if the FIFO was empty.
  - Pop on out_valid & out_ready; issued_cnt increments on each pop.
  - out_inst and out_valid hold stable while out_ready=0.
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, order preserved.
- Pointer wrap is modulo DEPTH; strict FIFO ordering across the wrap.
- out_inst is don't-care when out_valid=0; the implementation holds the last value.

Decomposition:
- Shared package holds:
  - opcode constants: R-type, lw, sw, beq
  - funct constants: add, sub, and, or
  - ALU control codes: 0000, 0001, 0010, 0110
  - in_kind encodings
- The existing decoder must import the same package.
- One sub-module: inst_fifo, a synchronous FIFO parameterised by width and DEPTH with push/pop/full/empty/count.
- Encoder logic and counters stay in inst_encoder.

Test Plan:
- R-type rs=1 rt=2 rd=3 shamt=0, alu_ctr 0010/0110/0000/0001 back-to-back, out_ready=1 -> 0x00221820, 0x00221822, 0x00221824, 0x00221825 in order, first one cycle after accept; issued_cnt=4.
- lw rs=29 rt=8 imm=0x0004 -> 0x8FA80004; sw same fields -> 0xAFA80004; beq rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
- R-type alu_ctr=0011 -> no out_valid, err pulses one cycle, err_cnt=1; 256 rejects -> err_cnt stays 255.
- out_ready=0, push 5 words with DEPTH=4 -> in_ready=0 after the 4th; 5th held; raise out_ready -> 5 words in order, no loss or duplicate, correct across pointer wrap.
- FIFO full, in_valid=1 and out_ready=1 in the same cycle -> pop only, push accepted next cycle.
- Assert rst_n=0 with 3 words buffered -> out_valid=0, err_cnt=0, issued_cnt=0 immediately (async); after release in_ready=1 and the old words never appear.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared encodings for the MIPS-style instruction encoder and decoder.
// Opcodes, funct codes, ALU control codes and request kinds.
package inst_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    KIND_R   = 2'b00,
    KIND_LW  = 2'b01,
    KIND_SW  = 2'b10,
    KIND_BEQ = 2'b11
  } kind_e;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with registered storage and power-of-two depth.
// Push is refused when full, even if a pop happens in the same cycle.
module inst_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs op kind, ALU code and fields into a 32-bit instruction word.
// Words are queued in a FIFO; bad R-type ALU codes are dropped and counted.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [3:0]       in_alu_ctr,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] issued_cnt
);

  kind_e            w_kind;
  logic [5:0]       w_funct;
  logic             w_fn_ok;
  logic [31:0]      w_inst;
  logic             w_bad;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             r_err;
  logic [7:0]       r_err_cnt;
  logic [CNT_W-1:0] r_issued;

  assign w_kind = kind_e'(in_kind);

  always_comb begin
    w_funct = '0;
    w_fn_ok = 1'b1;
    case (in_alu_ctr)
      ALU_ADD: w_funct = FN_ADD;
      ALU_SUB: w_funct = FN_SUB;
      ALU_AND: w_funct = FN_AND;
      ALU_OR:  w_funct = FN_OR;
      default: w_fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_inst = '0;
    w_bad  = 1'b0;
    unique case (w_kind)
      KIND_R: begin
        w_inst = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, w_funct};
        w_bad  = ~w_fn_ok;
      end
      KIND_LW:  w_inst = {OP_LW, in_rs, in_rt, in_imm};
      KIND_SW:  w_inst = {OP_SW, in_rs, in_rt, in_imm};
      KIND_BEQ: w_inst = {OP_BEQ, in_rs, in_rt, in_imm};
    endcase
  end

  // Rejected requests still complete the handshake, they just never enqueue.
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & ~w_bad;
  assign w_pop    = out_valid & out_ready;

  inst_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inst),
    .dout  (out_inst),
    .full  (w_full),
    .empty (w_empty)
  );

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_issued  <= '0;
    end else begin
      r_err <= w_accept & w_bad;
      if (w_accept && w_bad && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
      if (w_pop) r_issued <= r_issued + CNT_W'(1);
    end
  end

  assign err        = r_err;
  assign err_cnt    = r_err_cnt;
  assign issued_cnt = r_issued;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: driver queues expected words,
// a negedge monitor checks handshakes, words, err and counters.
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = '0;
  logic [3:0]  in_alu_ctr = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] issued_cnt;

  inst_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_alu_ctr (in_alu_ctr),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .err        (err),
    .err_cnt    (err_cnt),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  bit          in_rst = 1'b1;
  bit          pend_err = 1'b0;
  int          m_errcnt = 0;
  int          m_issued = 0;
  bit          use_lit = 1'b0;
  logic [31:0] lit = '0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_enc(
    input logic [1:0] k, input logic [3:0] a,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [15:0] imm, output bit bad);
    int unsigned ops[4];
    int unsigned fn;
    int unsigned w;
    ops[0] = 0; ops[1] = 35; ops[2] = 43; ops[3] = 4;
    bad = 1'b0;
    fn = 0;
    if (k == 2'd0) begin
      case (a)
        4'd2:    fn = 32;
        4'd6:    fn = 34;
        4'd0:    fn = 36;
        4'd1:    fn = 37;
        default: bad = 1'b1;
      endcase
    end
    w = ops[k] * (2 ** 26) + rs * (2 ** 21) + rt * (2 ** 16);
    if (k == 2'd0) w += rd * 2048 + sh * 64 + fn;
    else           w += imm;
    return w;
  endfunction

  function automatic logic [3:0] rand_alu(input bit good);
    logic [3:0] goods[4];
    logic [3:0] a;
    goods[0] = 4'd0; goods[1] = 4'd1; goods[2] = 4'd2; goods[3] = 4'd6;
    if (good) return goods[$urandom_range(0, 3)];
    do a = 4'($urandom_range(0, 15));
    while (a == 4'd0 || a == 4'd1 || a == 4'd2 || a == 4'd6);
    return a;
  endfunction

  // One clock: sample the handshake at negedge, update models after posedge.
  task automatic step(output bit acc);
    bit          a;
    bit          b;
    logic [31:0] w;
    @(negedge clk);
    a = in_valid && in_ready;
    w = ref_enc(in_kind, in_alu_ctr, in_rs, in_rt, in_rd, in_shamt,
                in_imm, b);
    if (use_lit) w = lit;
    @(posedge clk);
    #1;
    pend_err = a && b;
    if (a && b && m_errcnt < 255) m_errcnt++;
    if (a && !b) q.push_back(w);
    if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    acc = a;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    repeat (n) step(acc);
  endtask

  task automatic send(input logic [1:0] k, input logic [3:0] a,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, output int cyc);
    bit acc;
    in_kind = k; in_alu_ctr = a; in_rs = rs; in_rt = rt;
    in_rd = rd; in_shamt = sh; in_imm = imm;
    in_valid = 1'b1;
    cyc = 0;
    do begin
      step(acc);
      cyc++;
    end while (!acc && cyc < 200);
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never seen at %0t", $time);
    end
  endtask

  task automatic send_rand(input bit good);
    int c;
    logic [1:0] k;
    k = good ? 2'($urandom_range(0, 3)) : 2'd0;
    send(k, rand_alu(good), 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 16'($urandom), c);
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("err", 32'(err), 32'(pend_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        chk("issued_cnt", 32'(issued_cnt), 32'(16'(m_issued)));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_word: got %h expected none at %0t",
                     out_inst, $time);
          end else begin
            e = q.pop_front();
            chk("out_inst", out_inst, e);
          end
          m_issued++;
        end
      end
    end
  end

  initial begin : driver
    int c;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_issued", 32'(issued_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 1'b0;

    // R-type back-to-back with literal expectations
    out_ready = 1'b1;
    use_lit = 1'b1;
    lit = 32'h0022_1820; send(2'd0, 4'b0010, 5'd1, 5'd2, 5'd3, 5'd0, 16'($urandom), c);
    lit = 32'h0022_1822; send(2'd0, 4'b0110, 5'd1, 5'd2, 5'd3, 5'd0, 16'($urandom), c);
    lit = 32'h0022_1824; send(2'd0, 4'b0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'($urandom), c);
    lit = 32'h0022_1825; send(2'd0, 4'b0001, 5'd1, 5'd2, 5'd3, 5'd0, 16'($urandom), c);
    idle(3);
    chk("issued_after_rtype", 32'(issued_cnt), 32'd4);

    lit = 32'h8FA8_0004;
    send(2'd1, 4'($urandom), 5'd29, 5'd8, 5'($urandom), 5'($urandom), 16'h0004, c);
    lit = 32'hAFA8_0004;
    send(2'd2, 4'($urandom), 5'd29, 5'd8, 5'($urandom), 5'($urandom), 16'h0004, c);
    lit = 32'h1022_FFFF;
    send(2'd3, 4'($urandom), 5'd1, 5'd2, 5'($urandom), 5'($urandom), 16'hFFFF, c);
    use_lit = 1'b0;
    idle(3);

    // Reject path and saturation
    send(2'd0, 4'b0011, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, c);
    idle(2);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    repeat (256) send_rand(1'b0);
    idle(2);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Fill with consumer stalled, then pop and push in the same cycle
    out_ready = 1'b0;
    repeat (DEPTH) send_rand(1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(2'd1, 4'd0, 5'($urandom), 5'($urandom), 5'd0, 5'd0, 16'($urandom), c);
    chk("no_push_through", 32'(c), 32'd2);
    idle(DEPTH + 3);

    // Random mixed traffic with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_rand($urandom_range(0, 4) != 0);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(DEPTH + 3);
    chk("drained", 32'(q.size()), 32'd0);

    // Asynchronous reset with words buffered
    out_ready = 1'b0;
    repeat (3) send_rand(1'b1);
    idle(1);
    #2;
    in_rst = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_issued", 32'(issued_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    m_errcnt = 0;
    m_issued = 0;
    pend_err = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_rst = 1'b0;
    idle(6);
    use_lit = 1'b1;
    lit = 32'h8FA8_0004;
    send(2'd1, 4'd0, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, c);
    use_lit = 1'b0;
    idle(3);
    chk("post_rst_issued", 32'(issued_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
